// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator.
package product_accumulator_pkg;

    // Frame control states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } acc_state_e;

    // Default widths match the 2x2 multiplier feeding this block.
    localparam int unsigned DefaultProdW = 4;
    localparam int unsigned DefaultAccW  = 8;
    localparam int unsigned DefaultN     = 4;

    // Counter width able to hold 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream and frame-result output handshake.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = DefaultProdW,
    parameter int unsigned ACC_W  = DefaultAccW
) ();

    // Product stream from the multiplier.
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;

    // Frame result towards the consumer.
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    // Seen from the accumulator.
    modport slave (
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );

    // Seen from the producer/consumer side.
    modport master (
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder: acc + prod clamped to the accumulator range.
module product_accumulator_sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int unsigned PROD_W = DefaultProdW,
    parameter int unsigned ACC_W  = DefaultAccW
) (
    input  logic [ACC_W-1:0]  a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    // One extra bit exposes the carry out of the accumulator range.
    logic [ACC_W:0] wide_sum;

    // Add with headroom, then clamp to all-ones on carry.
    always_comb begin
        wide_sum = {1'b0, a_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, b_i};
        ovf_o    = wide_sum[ACC_W];
        sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums frames of N products into a saturating accumulator and hands each
// frame total downstream with a valid/ready handshake.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int unsigned N      = DefaultN,
    parameter int unsigned PROD_W = DefaultProdW,
    parameter int unsigned ACC_W  = DefaultAccW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    output logic                         busy,
    product_accumulator_if.slave         bus
);

    localparam int unsigned CntW = cnt_width(N);
    // cnt value before the edge that accepts the last product of a frame.
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    acc_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              sum_ovf_q, sum_ovf_d;

    logic              accept;
    logic              last_item;
    logic [ACC_W-1:0]  add_a;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic              frame_ovf;

    // Handshake and status outputs depend on state only.
    always_comb begin
        bus.in_ready  = (state_q != StHold);
        bus.out_valid = (state_q == StHold);
        busy          = (state_q == StAccum);
        bus.out_sum   = sum_q;
        bus.out_ovf   = sum_ovf_q;
    end

    // Adder operands: a fresh frame always starts from zero.
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        last_item = (cnt_q == LastCnt);
        add_a     = (state_q == StAccum) ? acc_q : '0;
    end

    product_accumulator_sat_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_adder (
        .a_i   (add_a),
        .b_i   (bus.in_prod),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // Sticky overflow including the product being accepted this cycle.
    always_comb begin
        frame_ovf = add_ovf | ((state_q == StAccum) ? ovf_q : 1'b0);
    end

    // Next-state and datapath update; clear aborts everything except out_sum.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;

        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_d = add_sum;
                        ovf_d = frame_ovf;
                        if (last_item) begin
                            // Frame complete: publish result, counter restarts.
                            state_d   = StHold;
                            cnt_d     = '0;
                            sum_d     = add_sum;
                            sum_ovf_d = frame_ovf;
                        end else begin
                            state_d = StAccum;
                            cnt_d   = cnt_q + CntW'(1);
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        state_d = StIdle;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 2-bit x 2-bit combinational multiplier.
- Consumes a stream of 4-bit products, sums a frame of N products into a saturating accumulator, then presents the frame sum with a valid/ready handshake.
- Forms the accumulate half of a small dot-product / MAC datapath; the multiplier output wires directly to in_prod.

Parameters:
- N, 4: products per frame; legal range 1..255.
- PROD_W, 4: product width; matches the multiplier output width.
- ACC_W, 8: accumulator and result width; must be >= PROD_W.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  in_prod is valid this cycle.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  PROD_W  unsigned product from the multiplier.
- out_valid  output  1  out_sum and out_ovf are valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  saturated frame sum.
- out_ovf  output  1  the frame saturated at least once.
- busy  output  1  a frame is partially accumulated (state ACCUM).

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; acc=0; cnt=0.
  - out_sum=0, out_ovf=0, out_valid=0, busy=0, in_ready=1 on the following cycle.
  - rst has priority over every other input.
- Accept rule: a product transfers on a clock edge where in_valid && in_ready. No transfer occurs otherwise; in_prod is ignored when in_valid=0.
- in_ready is 1 in IDLE and ACCUM, 0 in HOLD. It is a function of state only, never of in_valid.
- States:
  - IDLE: acc=0, cnt=0. On accept: acc=in_prod, cnt=1. Go to HOLD if N==1, else ACCUM.
  - ACCUM: on accept, acc = sat(acc+in_prod) and cnt=cnt+1. If the accepted item is the Nth (cnt==N-1 before the edge), load out_sum with the new sum, out_ovf with the frame overflow, and go to HOLD. Idle cycles (in_valid=0) hold all state.
  - HOLD: out_valid=1. out_sum and out_ovf are stable until the handshake. On out_ready=1, go to IDLE with out_valid=0 on the next cycle and acc, cnt and the overflow flag cleared.
- Latency: out_valid rises on the cycle after the edge that accepts the Nth product. Minimum frame period is N+1 cycles.
- Arithmetic:
  - Unsigned, computed in ACC_W+1 bits.
  - If the sum is > 2^ACC_W-1, the result is 2^ACC_W-1 and the sticky frame-overflow flag is set.
  - Once saturated, acc stays saturated for the rest of the frame.
  - in_prod values above 9 are not checked; they are summed as given.
- clear=1 (with rst=0):
  - Next state is IDLE, acc=0, cnt=0, overflow flag cleared, out_valid=0.
  - Any product offered in the same cycle is dropped.
  - clear in HOLD discards the pending result even if out_ready=1 in that cycle.
  - out_sum keeps its last value but is not valid.
- Simultaneous events:
  - HOLD with out_ready=1 and in_valid=1: the result is consumed and the product is not accepted (in_ready=0). The product is accepted in IDLE on the next cycle if still valid.
  - clear and the Nth accept in the same cycle: clear wins; no result is produced.
- busy=1 only in ACCUM.
- cnt width is clog2(N+1). cnt never exceeds N-1.

Decomposition:
- Shared package: state encodings IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2, and the default widths PROD_W=4, ACC_W=8.
- One natural sub-module: sat_adder. It is combinational, takes ACC_W + PROD_W inputs, and produces the saturated sum plus an overflow bit. The FSM and registers stay in product_accumulator.

Test Plan:
- Reset: hold rst 2 cycles -> out_valid=0, out_sum=0, out_ovf=0, busy=0, in_ready=1. Assert rst mid-frame after 2 products -> IDLE next cycle; the next frame sums from 0.
- Basic frame (N=4): products 1,4,9,6 on consecutive cycles with out_ready=1 -> out_valid=1 for exactly one cycle, one cycle after the 4th accept; out_sum=20; out_ovf=0. in_ready=0 during that cycle.
- Gaps and backpressure: products 2,_,3,_,_,9,1 (_ = in_valid low), out_ready=0 for 5 cycles -> out_sum=15 held stable, out_valid held, in_ready=0 throughout. A product offered during HOLD is not counted. out_ready=1 -> IDLE next cycle.
- Saturation (ACC_W=4, N=4): products 9,9,1,0 -> out_sum=15, out_ovf=1. The next frame 1,1,1,1 -> out_sum=4, out_ovf=0.
- clear: 2 products (4,4), then clear with in_valid=1, in_prod=9 -> product dropped, busy=0. Next frame 1,1,1,1 -> 4. Also clear during HOLD with out_ready=1 -> no handshake, out_valid=0 next cycle.
- N=1: single product 6 -> out_sum=6 one cycle later. Back-to-back frames with out_ready=1 -> one result every 2 cycles.
